// File: rtl/seg_pkg.sv
// Shared types and packing rules for the seven-segment scan blocks.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 8;

    typedef logic [3:0]  digit_t;
    typedef logic [2:0]  digit_sel_t;
    typedef logic [31:0] digit_word_t;

    // Digit k of a packed load word lives in bits [4k+3:4k].
    function automatic digit_t word_digit(digit_word_t w, digit_sel_t k);
        return w[{k, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/refresh_div.sv
// Free-running divider: tick is high on the terminal count of a 0..REFRESH_DIV-1 counter.
module refresh_div #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == TERMINAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit register file with time-multiplexed scan-out to the segment decoder.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [3:0]  wr_data,
    input  logic        wr_dp,
    input  logic        ld_en,
    input  logic [31:0] ld_word,
    input  logic [7:0]  en_mask,
    output logic [3:0]  num,
    output logic [2:0]  sel,
    output logic        dp,
    output logic        blank,
    output logic        scan_tick
);

    digit_t [NUM_DIGITS-1:0] digits_q;
    digit_t [NUM_DIGITS-1:0] digits_d;
    logic   [NUM_DIGITS-1:0] dps_q;
    logic   [NUM_DIGITS-1:0] dps_d;
    digit_sel_t              sel_next;
    logic                    tick;

    refresh_div #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_refresh_div (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    // Post-write register contents; the output register reads from these so a
    // write to the digit about to be shown is visible on the same edge.
    always_comb begin
        sel_next = tick ? sel + 3'd1 : sel;
        digits_d = digits_q;
        dps_d    = dps_q;
        if (ld_en) begin
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                digits_d[k] = word_digit(ld_word, digit_sel_t'(k));
            end
            dps_d = '0;
        end
        if (wr_en) begin
            digits_d[wr_addr] = wr_data;
            dps_d[wr_addr]    = wr_dp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q  <= '0;
            dps_q     <= '0;
            sel       <= '0;
            scan_tick <= 1'b0;
            num       <= '0;
            dp        <= 1'b0;
            blank     <= 1'b0;
        end else begin
            digits_q  <= digits_d;
            dps_q     <= dps_d;
            sel       <= sel_next;
            scan_tick <= tick;
            num       <= digits_d[sel_next];
            dp        <= dps_d[sel_next];
            blank     <= ~en_mask[sel_next];
        end
    end

endmodule
